// File: rtl/pc_pkg.sv
// pc_sequencer shared types: run/halt states and next-PC selects.
// Optional link/return support is enabled with PC_LINK_EN.
package pc_pkg;

  localparam int D_DEF  = 12;
  localparam int OW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_e;

  typedef enum logic [2:0] {
    HOLD,
    INC,
    JUMP,
    BRANCH,
    RET,
    ZERO
  } sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/observation bundle between harness and pc_sequencer.
// Link/Ret exist only when PC_LINK_EN is defined.
interface pc_sequencer_if #(
  parameter int D  = 12,
  parameter int OW = 8
);
  logic          Start;
  logic          Stall;
  logic          Halt;
  logic          Jump;
  logic [3:0]    JumpIdx;
  logic          Branch;
  logic [OW-1:0] Offset;
  logic [3:0]    LutAddr;
  logic [D-1:0]  LutTarget;
  logic [D-1:0]  PC;
  logic          Running;
  logic          Done;
`ifdef PC_LINK_EN
  logic          Link;
  logic          Ret;
`endif

  modport master (
    output Start, Stall, Halt, Jump,
    output JumpIdx, Branch, Offset,
    output LutTarget,
    input  LutAddr, PC, Running, Done
`ifdef PC_LINK_EN
    , output Link, Ret
`endif
  );

  modport slave (
    input  Start, Stall, Halt, Jump,
    input  JumpIdx, Branch, Offset,
    input  LutTarget,
    output LutAddr, PC, Running, Done
`ifdef PC_LINK_EN
    , input Link, Ret
`endif
  );

endinterface

// File: rtl/pc_next.sv
// Next-PC mux: hold, +1, table target, relative branch, return, zero.
// All adds are modulo 2**D; the offset is sign-extended to D bits.
module pc_next
  import pc_pkg::*;
#(
  parameter int D  = D_DEF,
  parameter int OW = OW_DEF
) (
  input  sel_e          sel_i,
  input  logic [D-1:0]  pc_i,
  input  logic [D-1:0]  target_i,
  input  logic [D-1:0]  link_i,
  input  logic [OW-1:0] off_i,
  output logic [D-1:0]  pc_o
);

  logic [D-1:0] off_x;
  logic [D-1:0] one;

  assign off_x = {{(D-OW){off_i[OW-1]}}, off_i};
  assign one   = {{(D-1){1'b0}}, 1'b1};

  // Select the next PC; carries out of the top bit are dropped.
  always_comb begin
    pc_o = pc_i;
    unique case (sel_i)
      HOLD:    pc_o = pc_i;
      INC:     pc_o = pc_i + one;
      JUMP:    pc_o = target_i;
      BRANCH:  pc_o = pc_i + off_x;
      RET:     pc_o = link_i;
      ZERO:    pc_o = '0;
      default: pc_o = pc_i;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: run/halt FSM plus PC (and link) registers.
// Define PC_LINK_EN to add Link/Ret and the link register.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int D  = D_DEF,
  parameter int OW = OW_DEF
) (
  input logic           Clk,
  input logic           Reset_n,
  pc_sequencer_if.slave bus
);

  state_e       state_q, state_d;
  sel_e         sel;
  logic [D-1:0] pc_q, pc_d;
  logic         run_q, done_q;
  logic [D-1:0] link_v;

`ifdef PC_LINK_EN
  logic [D-1:0] link_q;
  logic         link_we;
  assign link_v = link_q;
`else
  assign link_v = '0;
`endif

  assign bus.LutAddr = bus.JumpIdx;
  assign bus.PC      = pc_q;
  assign bus.Running = run_q;
  assign bus.Done    = done_q;

  pc_next #(
    .D  (D),
    .OW (OW)
  ) u_next (
    .sel_i    (sel),
    .pc_i     (pc_q),
    .target_i (bus.LutTarget),
    .link_i   (link_v),
    .off_i    (bus.Offset),
    .pc_o     (pc_d)
  );

  // Next state and PC select; Stall freezes everything, even Start.
  always_comb begin
    state_d = state_q;
    sel     = HOLD;
`ifdef PC_LINK_EN
    link_we = 1'b0;
`endif
    unique case (state_q)
      IDLE, HALTED: begin
        if (bus.Start && !bus.Stall) begin
          state_d = RUN;
          sel     = ZERO;
        end
      end
      RUN: begin
        if (bus.Stall) begin
          sel = HOLD;
        end else if (bus.Halt) begin
          state_d = HALTED;
`ifdef PC_LINK_EN
        end else if (bus.Ret) begin
          sel = RET;
`endif
        end else if (bus.Jump) begin
          sel = JUMP;
`ifdef PC_LINK_EN
          link_we = bus.Link;
`endif
        end else if (bus.Branch) begin
          sel = BRANCH;
        end else begin
          sel = INC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, PC and status flags; flags follow the state being entered.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      run_q   <= (state_d == RUN);
      done_q  <= (state_d == HALTED);
    end
  end

`ifdef PC_LINK_EN
  // Capture the return address on a linking jump.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      link_q <= '0;
    end else if (link_we) begin
      link_q <= pc_q + {{(D-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: per-scenario tables
// feed a scoreboard of expected PC/Running/Done after each edge.
module tb_pc_sequencer;

  logic Clk;
  logic Reset_n;

  pc_sequencer_if #(.D(12), .OW(8)) bus ();

  pc_sequencer #(.D(12), .OW(8)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [11:0] lut(logic [3:0] idx);
    case (idx)
      4'd1:    lut = 12'd18;
      4'd2:    lut = 12'd31;
      4'd3:    lut = 12'd7;
      4'd4:    lut = 12'd20;
      4'd5:    lut = 12'd10;
      default: lut = 12'hABC;
    endcase
  endfunction

  assign bus.LutTarget = lut(bus.LutAddr);

  typedef struct {
    bit         start, stall, halt, jump, branch, link, ret;
    logic [3:0] idx;
    logic [7:0] off;
    logic [11:0] pc;
    bit         run, done;
  } row_t;

  typedef struct {
    logic [11:0] pc;
    logic        run, done;
  } exp_t;

  exp_t sb[$];
  row_t tbl[$];
  int   ncmp = 0;
  int   nerr = 0;

  function automatic row_t R(bit start, bit stall, bit halt,
                             bit jump, bit branch,
                             logic [3:0] idx, logic [7:0] off,
                             logic [11:0] pc, bit run, bit done,
                             bit link = 0, bit ret = 0);
    row_t r;
    r.start = start; r.stall = stall; r.halt = halt;
    r.jump = jump; r.branch = branch; r.link = link; r.ret = ret;
    r.idx = idx; r.off = off;
    r.pc = pc; r.run = run; r.done = done;
    return r;
  endfunction

  task automatic drv(row_t r);
    bus.Start   = r.start;
    bus.Stall   = r.stall;
    bus.Halt    = r.halt;
    bus.Jump    = r.jump;
    bus.Branch  = r.branch;
    bus.JumpIdx = r.idx;
    bus.Offset  = r.off;
`ifdef PC_LINK_EN
    bus.Link    = r.link;
    bus.Ret     = r.ret;
`endif
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    drv(R(0,0,0,0,0,0,0,0,0,0));
    Reset_n = 1'b0;
    #3;
    ncmp++;
    if (bus.PC !== 12'd0 || bus.Running !== 1'b0 || bus.Done !== 1'b0) begin
      nerr++;
      $display("FAIL reset: pc=%h run=%b done=%b, want 000/0/0",
               bus.PC, bus.Running, bus.Done);
    end
    tick();
    Reset_n = 1'b1;
    tick();
    tbl.delete();
    tbl.push_back(R(0,0,0,1,0,4'd2,8'h00,12'd0,0,0));
    tbl.push_back(R(0,0,0,0,1,4'd0,8'h05,12'd0,0,0));
    tbl.push_back(R(0,1,1,0,0,4'd0,8'h00,12'd0,0,0));
    foreach (tbl[i]) begin
      drv(tbl[i]);
      sb.push_back('{pc: tbl[i].pc, run: tbl[i].run, done: tbl[i].done});
      tick();
      e = sb.pop_front();
      ncmp++;
      if ({bus.PC, bus.Running, bus.Done} !== {e.pc, e.run, e.done}) begin
        nerr++;
        $display("FAIL idle_ignore row %0d: pc=%h run=%b done=%b, want %h/%b/%b",
                 i, bus.PC, bus.Running, bus.Done, e.pc, e.run, e.done);
      end
    end
  endtask

  task automatic test_count_wrap();
    exp_t e;
    tbl.delete();
    tbl.push_back(R(1,0,0,0,0,0,8'h00,12'd0,1,0));
    for (int k = 1; k <= 4; k++)
      tbl.push_back(R(0,0,0,0,0,0,8'h00,12'(k),1,0));
    tbl.push_back(R(0,0,0,0,1,0,8'hFB,12'hFFF,1,0));
    tbl.push_back(R(0,0,0,0,0,0,8'h00,12'h000,1,0));
    for (int k = 1; k <= 3; k++)
      tbl.push_back(R(0,0,0,0,0,0,8'h00,12'(k),1,0));
    tbl.push_back(R(0,0,0,1,1,4'd2,8'h01,12'd31,1,0));
    tbl.push_back(R(0,0,0,0,1,4'd0,8'h7F,12'd158,1,0));
    foreach (tbl[i]) begin
      drv(tbl[i]);
      #1;
      ncmp++;
      if (bus.LutAddr !== tbl[i].idx) begin
        nerr++;
        $display("FAIL lutaddr row %0d: got %0d want %0d",
                 i, bus.LutAddr, tbl[i].idx);
      end
      sb.push_back('{pc: tbl[i].pc, run: tbl[i].run, done: tbl[i].done});
      tick();
      e = sb.pop_front();
      ncmp++;
      if ({bus.PC, bus.Running, bus.Done} !== {e.pc, e.run, e.done}) begin
        nerr++;
        $display("FAIL count_wrap row %0d: pc=%h run=%b done=%b, want %h/%b/%b",
                 i, bus.PC, bus.Running, bus.Done, e.pc, e.run, e.done);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    tbl.delete();
    tbl.push_back(R(0,0,0,1,0,4'd3,8'h00,12'd7,1,0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(R(0,1,0,1,0,4'd4,8'h00,12'd7,1,0));
    tbl.push_back(R(0,0,0,1,0,4'd4,8'h00,12'd20,1,0));
    foreach (tbl[i]) begin
      drv(tbl[i]);
      sb.push_back('{pc: tbl[i].pc, run: tbl[i].run, done: tbl[i].done});
      tick();
      e = sb.pop_front();
      ncmp++;
      if ({bus.PC, bus.Running, bus.Done} !== {e.pc, e.run, e.done}) begin
        nerr++;
        $display("FAIL stall row %0d: pc=%h run=%b done=%b, want %h/%b/%b",
                 i, bus.PC, bus.Running, bus.Done, e.pc, e.run, e.done);
      end
    end
  endtask

  task automatic test_halt_restart();
    exp_t e;
    tbl.delete();
    tbl.push_back(R(0,0,1,1,0,4'd2,8'h00,12'd20,0,1));
    tbl.push_back(R(0,0,0,1,0,4'd2,8'h00,12'd20,0,1));
    tbl.push_back(R(1,1,0,0,0,4'd0,8'h00,12'd20,0,1));
    tbl.push_back(R(0,0,0,0,0,4'd0,8'h00,12'd20,0,1));
    tbl.push_back(R(1,0,0,0,0,4'd0,8'h00,12'd0,1,0));
    tbl.push_back(R(1,0,0,0,0,4'd0,8'h00,12'd1,1,0));
    tbl.push_back(R(0,0,0,0,0,4'd0,8'h00,12'd2,1,0));
    foreach (tbl[i]) begin
      drv(tbl[i]);
      sb.push_back('{pc: tbl[i].pc, run: tbl[i].run, done: tbl[i].done});
      tick();
      e = sb.pop_front();
      ncmp++;
      if ({bus.PC, bus.Running, bus.Done} !== {e.pc, e.run, e.done}) begin
        nerr++;
        $display("FAIL halt_restart row %0d: pc=%h run=%b done=%b, want %h/%b/%b",
                 i, bus.PC, bus.Running, bus.Done, e.pc, e.run, e.done);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    drv(R(0,0,0,0,0,0,8'h00,0,0,0));
    #2;
    Reset_n = 1'b0;
    #1;
    ncmp++;
    if (bus.PC !== 12'd0 || bus.Running !== 1'b0 || bus.Done !== 1'b0) begin
      nerr++;
      $display("FAIL async_reset: pc=%h run=%b done=%b, want 000/0/0",
               bus.PC, bus.Running, bus.Done);
    end
    tick();
    Reset_n = 1'b1;
    drv(R(0,0,0,0,0,0,8'h00,0,0,0));
    sb.push_back('{pc: 12'd0, run: 1'b0, done: 1'b0});
    tick();
    e = sb.pop_front();
    ncmp++;
    if ({bus.PC, bus.Running, bus.Done} !== {e.pc, e.run, e.done}) begin
      nerr++;
      $display("FAIL post_reset_idle: pc=%h run=%b done=%b, want %h/%b/%b",
               bus.PC, bus.Running, bus.Done, e.pc, e.run, e.done);
    end
  endtask

`ifdef PC_LINK_EN
  task automatic test_link();
    exp_t e;
    tbl.delete();
    tbl.push_back(R(1,0,0,0,0,4'd0,8'h00,12'd0,1,0));
    tbl.push_back(R(0,0,0,1,0,4'd5,8'h00,12'd10,1,0));
    tbl.push_back(R(0,0,0,1,0,4'd1,8'h00,12'd18,1,0,1,0));
    tbl.push_back(R(0,0,0,0,1,4'd0,8'h07,12'd25,1,0));
    tbl.push_back(R(0,0,0,1,0,4'd2,8'h00,12'd11,1,0,0,1));
    tbl.push_back(R(0,0,1,0,0,4'd0,8'h00,12'd11,0,1,0,1));
    foreach (tbl[i]) begin
      drv(tbl[i]);
      sb.push_back('{pc: tbl[i].pc, run: tbl[i].run, done: tbl[i].done});
      tick();
      e = sb.pop_front();
      ncmp++;
      if ({bus.PC, bus.Running, bus.Done} !== {e.pc, e.run, e.done}) begin
        nerr++;
        $display("FAIL link row %0d: pc=%h run=%b done=%b, want %h/%b/%b",
                 i, bus.PC, bus.Running, bus.Done, e.pc, e.run, e.done);
      end
    end
  endtask
`endif

  initial begin
    Reset_n = 1'b0;
    test_reset();
    test_count_wrap();
    test_stall();
    test_halt_restart();
    test_async_reset();
`ifdef PC_LINK_EN
    test_link();
`endif
    ncmp++;
    if (sb.size() !== 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
